// File: rtl/nec_pkg.sv
// NEC IR shared types and timing constants.
// Used by both the transmitter and the receiver.
package nec_pkg;

    typedef enum logic [3:0] {
        IDLE,
        LEAD_MARK,
        LEAD_SPACE,
        BIT_MARK,
        BIT_SPACE,
        STOP_MARK,
        GAP,
        REP_MARK,
        REP_SPACE
    } nec_state_t;

    localparam int LEAD_MARK_U     = 16;
    localparam int LEAD_SPACE_U    = 8;
    localparam int REP_SPACE_U     = 4;
    localparam int BIT0_SPACE_U    = 1;
    localparam int BIT1_SPACE_U    = 3;
    localparam int BIT_MARK_U      = 1;
    localparam int STOP_MARK_U     = 1;
    localparam int FRAME_TICKS_DEF = 192;

    localparam int UNIT_W = 5;

    function automatic logic is_mark(input nec_state_t s);
        return (s == LEAD_MARK) || (s == BIT_MARK) ||
               (s == STOP_MARK) || (s == REP_MARK);
    endfunction

endpackage

// File: rtl/nec_carrier_gen.sv
// IR carrier generator: counter restarted at each mark entry,
// registered output already gated by the mark enable.
module nec_carrier_gen #(
    parameter int PERIOD = 1316,
    parameter int HIGH   = 438
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_carrier
);

    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_nxt;
    logic          r_carrier;

    always_comb begin
        w_nxt = r_cnt + CW'(1);
        if (r_cnt == CW'(PERIOD - 1)) begin
            w_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_carrier <= 1'b0;
        end else if (i_clr) begin
            r_cnt     <= '0;
            r_carrier <= (HIGH > 0);
        end else if (i_en) begin
            r_cnt     <= w_nxt;
            r_carrier <= (int'(w_nxt) < HIGH);
        end else begin
            r_cnt     <= '0;
            r_carrier <= 1'b0;
        end
    end

    assign o_carrier = r_carrier;

endmodule

// File: rtl/nec_ir_tx.sv
// NEC IR transmitter: full frames and repeat codes with a
// fixed start-to-start period and a modulated LED drive.
module nec_ir_tx
    import nec_pkg::*;
#(
    parameter int TICK_CYCLES    = 28125,
    parameter int CARRIER_PERIOD = 1316,
    parameter int CARRIER_HIGH   = 438,
    parameter int FRAME_TICKS    = FRAME_TICKS_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       send,
    input  logic       rpt,
    input  logic [7:0] addr,
    input  logic [7:0] cmd,
    output logic       ready,
    output logic       done,
    output logic       ir_env,
    output logic       ir_led
);

    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    nec_state_t        r_state;
    nec_state_t        w_state_nxt;

    logic [PW-1:0]     r_pre;
    logic [UNIT_W-1:0] r_ucnt;
    logic [UNIT_W-1:0] w_dur;
    logic [7:0]        r_fcnt;
    logic [5:0]        r_bit;
    logic [31:0]       r_shift;

    logic              w_accept;
    logic              w_tick;
    logic              w_unit_end;
    logic              w_last_bit;
    logic              w_gap_end;

    logic              w_mark_d;
    logic              w_clr;
    logic              w_ready_d;
    logic              w_done_d;
    logic              w_env_d;
    logic              w_carrier;

    logic              r_ready;
    logic              r_done;
    logic              r_env;

    assign w_accept   = (r_state == IDLE) & (send | rpt);
    assign w_tick     = (r_pre == PW'(TICK_CYCLES - 1));
    assign w_unit_end = w_tick & (r_ucnt == w_dur - UNIT_W'(1));
    assign w_last_bit = (r_bit == 6'd31);
    assign w_gap_end  = w_tick & (int'(r_fcnt) >= FRAME_TICKS - 1);

    always_comb begin
        w_dur = UNIT_W'(1);
        unique case (r_state)
            LEAD_MARK,
            REP_MARK:   w_dur = UNIT_W'(LEAD_MARK_U);
            LEAD_SPACE: w_dur = UNIT_W'(LEAD_SPACE_U);
            REP_SPACE:  w_dur = UNIT_W'(REP_SPACE_U);
            BIT_MARK:   w_dur = UNIT_W'(BIT_MARK_U);
            STOP_MARK:  w_dur = UNIT_W'(STOP_MARK_U);
            BIT_SPACE:  w_dur = r_shift[0] ? UNIT_W'(BIT1_SPACE_U)
                                           : UNIT_W'(BIT0_SPACE_U);
            default:    w_dur = UNIT_W'(1);
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (send) begin
                    w_state_nxt = LEAD_MARK;
                end else if (rpt) begin
                    w_state_nxt = REP_MARK;
                end
            end
            LEAD_MARK:  if (w_unit_end) w_state_nxt = LEAD_SPACE;
            LEAD_SPACE: if (w_unit_end) w_state_nxt = BIT_MARK;
            BIT_MARK:   if (w_unit_end) w_state_nxt = BIT_SPACE;
            BIT_SPACE: begin
                if (w_unit_end) begin
                    w_state_nxt = w_last_bit ? STOP_MARK : BIT_MARK;
                end
            end
            STOP_MARK:  if (w_unit_end) w_state_nxt = GAP;
            GAP:        if (w_gap_end) w_state_nxt = IDLE;
            REP_MARK:   if (w_unit_end) w_state_nxt = REP_SPACE;
            REP_SPACE:  if (w_unit_end) w_state_nxt = STOP_MARK;
            default:    w_state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so that they
    // change on the same edge as the state register.
    always_comb begin
        w_mark_d  = is_mark(w_state_nxt);
        w_clr     = w_mark_d & ~is_mark(r_state);
        w_ready_d = (w_state_nxt == IDLE);
        w_done_d  = (r_state == GAP) & (w_state_nxt == IDLE);
        w_env_d   = ~w_mark_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ready <= 1'b1;
            r_done  <= 1'b0;
            r_env   <= 1'b1;
        end else begin
            r_ready <= w_ready_d;
            r_done  <= w_done_d;
            r_env   <= w_env_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pre   <= '0;
            r_ucnt  <= '0;
            r_fcnt  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else if (w_accept) begin
            r_pre   <= '0;
            r_ucnt  <= '0;
            r_fcnt  <= '0;
            r_bit   <= '0;
            r_shift <= {~cmd, cmd, ~addr, addr};
        end else if (r_state != IDLE) begin
            r_pre <= w_tick ? '0 : r_pre + PW'(1);
            if (w_tick) begin
                if (int'(r_fcnt) < FRAME_TICKS) begin
                    r_fcnt <= r_fcnt + 8'd1;
                end
                if (w_state_nxt != r_state) begin
                    r_ucnt <= '0;
                end else begin
                    r_ucnt <= r_ucnt + UNIT_W'(1);
                end
            end
            if ((r_state == BIT_SPACE) && w_unit_end) begin
                r_shift <= r_shift >> 1;
                r_bit   <= w_last_bit ? 6'd0 : r_bit + 6'd1;
            end
        end
    end

    nec_carrier_gen #(
        .PERIOD (CARRIER_PERIOD),
        .HIGH   (CARRIER_HIGH)
    ) u_carrier (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (w_clr),
        .i_en      (w_mark_d),
        .o_carrier (w_carrier)
    );

    assign ready  = r_ready;
    assign done   = r_done;
    assign ir_env = r_env;
    assign ir_led = w_carrier;

endmodule

// File: doc/nec_ir_tx.md
# nec_ir_tx

NEC infrared transmitter. It serialises an 8-bit address and an 8-bit command into a complete NEC frame (leader, 32 data bits, stop mark) or a repeat code, and drives an IR LED with a 38 kHz carrier. It is the upstream stage of the NEC receiver/7-segment path, and on the board it drives that receiver in loopback for self-test and remote emulation. Default timing assumes clk = 50 MHz.

## Interface
Parameters:
- TICK_CYCLES, 28125: clk cycles per NEC unit (562.5 us).
- CARRIER_PERIOD, 1316: clk cycles per carrier period (~38 kHz).
- CARRIER_HIGH, 438: carrier high cycles per period (~1/3 duty).
- FRAME_TICKS, 192: minimum start-to-start frame period in units (108 ms).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- send  in  1  request to transmit a full frame; sampled only when ready=1.
- rpt  in  1  request to transmit a repeat code; sampled only when ready=1; send has priority.
- addr  in  8  address; latched on accept.
- cmd  in  8  command; latched on accept.
- ready  out  1  idle and able to accept a request.
- done  out  1  one-cycle pulse when a frame or repeat period ends.
- ir_env  out  1  unmodulated envelope, receiver polarity: 0 during mark, 1 during space/idle.
- ir_led  out  1  modulated LED drive: carrier during mark, 0 otherwise.

## Operation
- Accept: ready=1 and send=1 (or rpt=1 with send=0). Latch the payload {~cmd, cmd, ~addr, addr} into a 32-bit shift register. Transmit LSB first: addr[0] first, ~cmd[7] last.
- FSM states: IDLE, LEAD_MARK (16 units), LEAD_SPACE (8), BIT_MARK (1), BIT_SPACE (1 for bit 0, 3 for bit 1), STOP_MARK (1), GAP, REP_MARK (16), REP_SPACE (4).
- Full frame path: IDLE → LEAD_MARK → LEAD_SPACE → (BIT_MARK → BIT_SPACE) ×32 → STOP_MARK → GAP → IDLE.
- Repeat path: IDLE → REP_MARK → REP_SPACE → STOP_MARK → GAP → IDLE.
- Bit counter: 6 bits, counts 0..31. The shift register shifts right at the end of each BIT_SPACE. After 32 bits the FSM goes to STOP_MARK.
- Unit prescaler: counts 0..TICK_CYCLES-1, cleared on accept. Each state's duration is counted in whole units.
- Frame unit counter: 8 bits, cleared on accept, incremented once per unit, saturates at FRAME_TICKS. GAP exits when it reaches FRAME_TICKS. The start-to-start period is therefore exactly FRAME_TICKS units for both frames and repeats.
- Carrier counter: cleared on entry to every mark state, so every mark starts with ir_led=1. ir_led = mark & (carrier_cnt < CARRIER_HIGH). Wraps at CARRIER_PERIOD-1.
- ready=1 only in IDLE. send/rpt while busy are ignored and are not queued; addr/cmd changes during a frame have no effect.
- Reset mid-frame: returns to IDLE immediately and truncates the frame.

## Timing
- Reset values: ready=1, done=0, ir_env=1, ir_led=0; all counters 0; state IDLE.
- Accept on edge t: at t+1, ready=0, ir_env=0 and ir_led=1.
- The state of ir_env changes exactly on unit boundaries: k×TICK_CYCLES cycles after t+1.
- Full frame: ir_env final rising edge at (24 + Σbit lengths + 1) units. done pulses at FRAME_TICKS×TICK_CYCLES cycles after t+1. ready=1 on the same cycle as done.
- Back-to-back: a request asserted on the done cycle is accepted at that edge (no dead cycle).
- Simultaneous send and rpt: frame transmitted, rpt dropped.
- All outputs are registered.

## Structure
- Package nec_pkg holds:
  - the FSM state enum;
  - unit constants LEAD_MARK_U=16, LEAD_SPACE_U=8, REP_SPACE_U=4, BIT0_SPACE_U=1, BIT1_SPACE_U=3;
  - FRAME_TICKS default. The receiver uses the same package.
- Sub-module nec_carrier_gen: parameterised carrier counter with clear and enable inputs, producing the carrier bit. Everything else lives in nec_ir_tx.

## Test plan
All scenarios use sim parameters TICK_CYCLES=10, CARRIER_PERIOD=4, CARRIER_HIGH=2, FRAME_TICKS=192.
- Reset: hold rst_n=0 for 5 cycles → ready=1, ir_env=1, ir_led=0, done=0; release → outputs unchanged with no request.
- Frame addr=0x00, cmd=0x16 (payload 0x00,0xFF,0x16,0xE9; 16 ones, 16 zeros) → ir_env low for 160 cycles, then high for 80. The decoded pulse sequence matches LSB-first bits. Final rising edge 1210 cycles after accept; done at 1920; ready back at 1920.
- Repeat: rpt=1 → ir_env low 160, high 40, low 10, then high. done at 1920 cycles.
- Carrier: during any mark, ir_led pattern is 1,1,0,0 repeating, starting with 1 at each mark start; ir_led=0 throughout every space.
- Busy/priority: send pulse at cycle 500 of a frame → ignored, no second frame. send=rpt=1 in IDLE → full frame. A request on the done cycle → new leader starts on the next cycle.
- Reset mid-frame: rst_n=0 at cycle 700 → next cycle IDLE, ir_env=1, ir_led=0, ready=1, no done pulse.
